// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32I/RV64I immediate decoder stage with optional skid buffer
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       imm_type,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_MISC    = 7'b0001111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_S     = 3'd2;
    localparam logic [2:0] T_B     = 3'd3;
    localparam logic [2:0] T_U     = 3'd4;
    localparam logic [2:0] T_J     = 3'd5;
    localparam logic [2:0] T_SHAMT = 3'd6;
    localparam logic [2:0] T_ZIMM  = 3'd7;

    localparam bit RV64 = (XLEN == 64);
    localparam int PW   = XLEN + 4 + TAG_W;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
        logic [XLEN-1:0] r;
        r      = '0;
        r[5:0] = v;
        return r;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'h000};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    logic            dec_ill;

    always_comb begin
        dec_imm  = '0;
        dec_type = T_NONE;
        dec_ill  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_type = T_U;
                dec_imm  = sext32(imm_u);
            end
            OPC_JAL: begin
                dec_type = T_J;
                dec_imm  = sext32(imm_j);
            end
            OPC_JALR, OPC_LOAD, OPC_MISC: begin
                dec_type = T_I;
                dec_imm  = sext32(imm_i);
            end
            OPC_BRANCH: begin
                dec_type = T_B;
                dec_imm  = sext32(imm_b);
            end
            OPC_STORE: begin
                dec_type = T_S;
                dec_imm  = sext32(imm_s);
            end
            OPC_OP_IMM: begin
                // funct3 001/101 are the shifts; funct7 (arith/logical) never reaches imm
                if (funct3[1:0] == 2'b01) begin
                    dec_type = T_SHAMT;
                    dec_imm  = zext6(RV64 ? instr[25:20] : {1'b0, instr[24:20]});
                end else begin
                    dec_type = T_I;
                    dec_imm  = sext32(imm_i);
                end
            end
            OPC_OP_IMM32: begin
                if (!RV64) begin
                    dec_ill = 1'b1;
                end else if (funct3[1:0] == 2'b01) begin
                    dec_type = T_SHAMT;
                    dec_imm  = zext6({1'b0, instr[24:20]});
                end else begin
                    dec_type = T_I;
                    dec_imm  = sext32(imm_i);
                end
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    dec_type = T_ZIMM;
                    dec_imm  = zext6({1'b0, instr[19:15]});
                end else begin
                    dec_type = T_I;
                    dec_imm  = sext32(imm_i);
                end
            end
            OPC_OP: begin
                dec_ill = 1'b0;
            end
            OPC_OP32: begin
                dec_ill = !RV64;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    logic [PW-1:0] dec_word;
    logic [PW-1:0] main_q;
    logic          accept;

    assign dec_word = {dec_imm, dec_type, dec_ill, in_tag};
    assign accept   = in_valid && in_ready;
    assign {imm, imm_type, illegal, out_tag} = main_q;

    generate
        if (SKID != 0) begin : g_skid
            logic          skid_valid;
            logic [PW-1:0] skid_q;

            // skid_valid is a flop, so in_ready has no combinational path from out_ready
            assign in_ready = !skid_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid  <= 1'b0;
                    main_q     <= '0;
                    skid_valid <= 1'b0;
                    skid_q     <= '0;
                end else if (!out_valid || out_ready) begin
                    if (skid_valid) begin
                        main_q     <= skid_q;
                        out_valid  <= 1'b1;
                        skid_valid <= 1'b0;
                    end else begin
                        out_valid <= accept;
                        if (accept) begin
                            main_q <= dec_word;
                        end
                    end
                end else if (accept) begin
                    skid_q     <= dec_word;
                    skid_valid <= 1'b1;
                end
            end
        end else begin : g_single
            assign in_ready = !out_valid || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    main_q    <= '0;
                end else if (!out_valid || out_ready) begin
                    out_valid <= accept;
                    if (accept) begin
                        main_q <= dec_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, registered immediate generator for the next-generation core datapath. It decodes the immediate of every RV32I/RV64I instruction format, including the SYSTEM-CSR zimm and OP-IMM-32 shift amounts. It also classifies the format and flags unsupported opcodes. It sits between fetch and execute as one valid/ready pipeline stage, with an optional skid buffer for full throughput under backpressure, and carries a sideband tag (PC, etc.) alongside the instruction.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag passed through unchanged; minimum 1.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready.
- clk  input  1  core clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instr/in_tag valid.
- in_ready  output  1  stage can accept; a transfer occurs when in_valid and in_ready are both high at an edge.
- instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband.
- out_valid  output  1  output fields valid.
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.
- imm  output  XLEN  decoded immediate.
- imm_type  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- illegal  output  1  opcode not supported for this XLEN.
- out_tag  output  TAG_W  tag of the instruction on the output.

## Operation
- Decode is combinational from instr[6:0] and funct3 = instr[14:12]. The result is registered on acceptance.
- LUI 0110111 and AUIPC 0010111: U, {instr[31:12], 12'h0}, sign-extended to XLEN.
- JAL 1101111: J, sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- JALR 1100111, LOAD 0000011, MISC-MEM 0001111: I, sext(instr[31:20]).
- BRANCH 1100011: B, sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- STORE 0100011: S, sext({instr[31:25], instr[11:7]}).
- OP-IMM 0010011:
  - funct3 001 or 101: SHAMT, zero-extended instr[24:20] for XLEN=32, instr[25:20] for XLEN=64. funct7 bits are never part of imm.
  - Other funct3: I, sign-extended.
- OP-IMM-32 0011011, XLEN=64 only: same rules as OP-IMM, but shamt is always instr[24:20].
- SYSTEM 1110011:
  - funct3[2]=1: ZIMM, zero-extended instr[19:15].
  - Otherwise: I, sign-extended.
- OP 0110011, plus OP-32 0111011 when XLEN=64: NONE, imm=0, illegal=0.
- Any other opcode, including 0011011/0111011 when XLEN=32: NONE, imm=0, illegal=1.
- The tag travels with its instruction. Output order always equals input order; no drop, no duplication.
- SKID=1:
  - State is main register (out_*) plus skid register.
  - in_ready = !skid_valid, taken from a flop.
  - Accept while main is empty, or main is draining in the same cycle: data goes to main.
  - Accept while main is full and not draining: data goes to skid.
  - On a main drain with skid_valid set: skid moves to main.
- SKID=0:
  - in_ready = !out_valid | out_ready.
  - Accept loads main. A drain without an accept clears out_valid.

## Timing
- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle while out_ready=1, for both SKID settings.
- Reset, asynchronous and immediate:
  - out_valid=0, skid empty, in_ready=1.
  - imm=0, imm_type=0, illegal=0, out_tag=0.
- Reset mid-transfer discards all held instructions. The first accept after deassertion behaves exactly as after power-up.
- Simultaneous accept and drain with SKID=1 and the skid empty: main takes the new data and the skid stays empty.
- Once out_valid is asserted, output fields stay stable until the transfer completes.
- Accepting while full is impossible by construction. The bench checks that in_ready is never high when both entries are occupied and not draining.

## Test plan
- XLEN=32, decode, one instruction each with out_ready=1:
  - 0xFFF00093 -> imm 0xFFFFFFFF, type I.
  - 0x00309093 -> imm 0x3, type SHAMT.
  - 0x41F0D093 -> imm 0x1F, type SHAMT.
  - 0xFE000EE3 -> imm 0xFFFFFFFC, type B.
  - 0x123450B7 -> imm 0x12345000, type U.
- XLEN=64:
  - 0x800000B7 -> imm 0xFFFFFFFF80000000, type U.
  - 0x03F09093 -> imm 0x3F, type SHAMT.
  - 0x0000001B -> imm 0, type I, illegal 0.
  - The same 0x0000001B under XLEN=32 -> illegal 1, imm 0.
- CSR and illegal:
  - 0x3401E073 -> ZIMM, imm 0x3.
  - 0x0000007F -> illegal 1, type NONE, imm 0.
- Backpressure, SKID=1:
  - Hold out_ready=0 and stream tags 1..4 with in_valid=1: tags 1 and 2 are accepted, then in_ready=0.
  - Release out_ready: outputs come out as tags 1, 2, 3, 4 in order, one per cycle, with no gaps.
- Same stream with SKID=0: in_ready follows !out_valid | out_ready combinationally, and order is preserved.
- Assert rst_n=0 for 1 cycle with both entries full: out_valid=0 and in_ready=1 immediately. The next instruction appears on the output 1 cycle after its accept.
